// File: rtl/vending_controller.sv
// vending_controller
//   Coin/keypad vending FSM for NUM_ITEMS products. Keeps a per-item price
//   table (input), per-item inventory counters with restock, a credit balance
//   in nickel units, and an idle timeout that auto-refunds. Change and refunds
//   are paid greedily (quarter, dime, nickel) over a valid/ready handshake.
//
//   Optional feature macro: VEND_CREDIT_EN (card payment from IDLE).
//
//   Ports
//     clk, rst                        clock, synchronous active-low reset
//     nickel/dime/quarter/dollar      one-cycle coin pulses
//     select, index                   selection request and item index
//     cancel                          refund request
//     cost                            flattened price table, PRICE_W per item
//     restock_en/_index/_count        overwrite one item's inventory
//     coin_ready                      dispenser accepts the presented coin
//     coin_valid, coin_type           change coin request (01 N, 10 D, 11 Q)
//     vend_valid, vend_index          one-cycle vend command
//     coin_reject                     inserted coin returned (pulse)
//     sold_out, insufficient          status pulses
//     balance, inventory              current credit / flattened stock counts
//     card_present, card_funds,       (VEND_CREDIT_EN only) card payment
//     card_debit, card_debit_valid
//   Assumes BAL_W >= PRICE_W.
module vending_controller #(
   parameter int NUM_ITEMS      = 8,
   parameter int PRICE_W        = 6,
   parameter int BAL_W          = 7,
   parameter int INV_W          = 3,
   parameter int TIMEOUT_CYCLES = 1000000,
   localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         nickel,
   input  logic                         dime,
   input  logic                         quarter,
   input  logic                         dollar,
   input  logic                         select,
   input  logic [IDX_W-1:0]             index,
   input  logic                         cancel,
   input  logic [NUM_ITEMS*PRICE_W-1:0] cost,
   input  logic                         restock_en,
   input  logic [IDX_W-1:0]             restock_index,
   input  logic [INV_W-1:0]             restock_count,
   input  logic                         coin_ready,
`ifdef VEND_CREDIT_EN
   input  logic                         card_present,
   input  logic [BAL_W-1:0]             card_funds,
   output logic [PRICE_W-1:0]           card_debit,
   output logic                         card_debit_valid,
`endif
   output logic                         coin_valid,
   output logic [1:0]                   coin_type,
   output logic                         vend_valid,
   output logic [IDX_W-1:0]             vend_index,
   output logic                         coin_reject,
   output logic                         sold_out,
   output logic                         insufficient,
   output logic [BAL_W-1:0]             balance,
   output logic [NUM_ITEMS*INV_W-1:0]   inventory
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W:0]   NI       = (IDX_W+1)'(NUM_ITEMS);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

   state_t             state_q;
   logic [BAL_W-1:0]   bal_q;
   logic [INV_W-1:0]   inv_q [NUM_ITEMS];
   logic [TMR_W-1:0]   tmr_q;
   logic [IDX_W-1:0]   vidx_q;
   logic [PRICE_W-1:0] price_q;
   logic               coin_valid_q, vend_valid_q, coin_reject_q;
   logic               sold_out_q, insufficient_q;
   logic [1:0]         coin_type_q;
`ifdef VEND_CREDIT_EN
   logic               card_q, card_debit_valid_q;
   logic [PRICE_W-1:0] card_debit_q;
`endif

   logic [PRICE_W-1:0] price_a [NUM_ITEMS];

   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
      assign price_a[g]                  = cost[g*PRICE_W +: PRICE_W];
      assign inventory[g*INV_W +: INV_W] = inv_q[g];
   end

   // Greedy change choice for a remaining balance.
   function automatic logic [1:0] pick(input logic [BAL_W-1:0] b);
      if (b >= BAL_W'(5))      pick = 2'b11;
      else if (b >= BAL_W'(2)) pick = 2'b10;
      else                     pick = 2'b01;
   endfunction

   function automatic logic [BAL_W-1:0] coin_value(input logic [1:0] t);
      case (t)
         2'b11:   coin_value = BAL_W'(5);
         2'b10:   coin_value = BAL_W'(2);
         default: coin_value = BAL_W'(1);
      endcase
   endfunction

   logic [BAL_W:0]     coin_val, bal_sum;
   logic [2:0]         n_coins;
   logic               any_coin, coin_ok, cancel_go, sel_try, sel_go, sold, insuf;
   logic               sel_idx_ok, sel_stock, sel_afford, timeout;
   logic [PRICE_W-1:0] sel_price;
   logic [BAL_W-1:0]   vend_rem, chg_rem;
   logic               card_go;

   always_comb begin
      coin_val = '0;
      if (dollar)       coin_val = (BAL_W+1)'(20);
      else if (quarter) coin_val = (BAL_W+1)'(5);
      else if (dime)    coin_val = (BAL_W+1)'(2);
      else if (nickel)  coin_val = (BAL_W+1)'(1);
      n_coins  = 3'(nickel) + 3'(dime) + 3'(quarter) + 3'(dollar);
      any_coin = (n_coins != 3'd0);
      // Extra MSB catches a sum that no longer fits in the balance register.
      bal_sum  = {1'b0, bal_q} + coin_val;

      sel_idx_ok = ({1'b0, index} < NI);
      sel_price  = sel_idx_ok ? price_a[index] : '0;
      sel_stock  = sel_idx_ok && (inv_q[index] != '0);
      sel_afford = (bal_q >= BAL_W'(sel_price));

      timeout   = (state_q == S_COLLECT) && (tmr_q == TMR_LAST);
      cancel_go = (state_q == S_COLLECT) && (cancel || timeout);
      sel_try   = (state_q == S_COLLECT) && select && !cancel_go;
      sel_go    = sel_try && sel_stock && sel_afford;
      sold      = sel_try && !sel_stock;
      insuf     = sel_try && sel_stock && !sel_afford;

`ifdef VEND_CREDIT_EN
      card_go = (state_q == S_IDLE) && select && card_present && sel_stock &&
                (card_funds >= BAL_W'(sel_price));
`else
      card_go = 1'b0;
`endif

      // A coin loses to any same-cycle transition out of IDLE/COLLECT.
      coin_ok = any_coin && (n_coins == 3'd1) && !bal_sum[BAL_W] &&
                ((state_q == S_IDLE && !card_go) ||
                 (state_q == S_COLLECT && !cancel_go && !sel_go));

      vend_rem = bal_q - BAL_W'(price_q);
      chg_rem  = bal_q - coin_value(coin_type_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         bal_q          <= '0;
         tmr_q          <= '0;
         vidx_q         <= '0;
         price_q        <= '0;
         coin_valid_q   <= 1'b0;
         coin_type_q    <= 2'b00;
         vend_valid_q   <= 1'b0;
         coin_reject_q  <= 1'b0;
         sold_out_q     <= 1'b0;
         insufficient_q <= 1'b0;
         for (int i = 0; i < NUM_ITEMS; i++) inv_q[i] <= '0;
`ifdef VEND_CREDIT_EN
         card_q             <= 1'b0;
         card_debit_q       <= '0;
         card_debit_valid_q <= 1'b0;
`endif
      end else begin
         vend_valid_q   <= 1'b0;
         coin_reject_q  <= any_coin && !coin_ok;
         sold_out_q     <= sold;
         insufficient_q <= insuf;
`ifdef VEND_CREDIT_EN
         card_debit_valid_q <= 1'b0;
`endif

         case (state_q)
            S_IDLE: begin
               if (card_go) begin
`ifdef VEND_CREDIT_EN
                  card_q             <= 1'b1;
                  card_debit_q       <= sel_price;
                  card_debit_valid_q <= 1'b1;
`endif
                  state_q      <= S_VEND;
                  vidx_q       <= index;
                  price_q      <= sel_price;
                  vend_valid_q <= 1'b1;
               end else if (coin_ok) begin
                  state_q <= S_COLLECT;
                  bal_q   <= bal_sum[BAL_W-1:0];
                  tmr_q   <= '0;
               end
            end
            S_COLLECT: begin
               if (cancel_go) begin
                  // Balance is always non-zero here: COLLECT is entered by a coin.
                  state_q      <= S_CHANGE;
                  coin_valid_q <= 1'b1;
                  coin_type_q  <= pick(bal_q);
               end else if (sel_go) begin
`ifdef VEND_CREDIT_EN
                  card_q       <= 1'b0;
`endif
                  state_q      <= S_VEND;
                  vidx_q       <= index;
                  price_q      <= sel_price;
                  vend_valid_q <= 1'b1;
               end else begin
                  if (coin_ok) bal_q <= bal_sum[BAL_W-1:0];
                  tmr_q <= (coin_ok || select) ? '0 : tmr_q + 1'b1;
               end
            end
            S_VEND: begin
`ifdef VEND_CREDIT_EN
               if (card_q) state_q <= S_IDLE;
               else
`endif
               begin
                  bal_q <= vend_rem;
                  if (vend_rem != '0) begin
                     state_q      <= S_CHANGE;
                     coin_valid_q <= 1'b1;
                     coin_type_q  <= pick(vend_rem);
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_CHANGE: begin
               if (coin_valid_q && coin_ready) begin
                  bal_q <= chg_rem;
                  if (chg_rem == '0) begin
                     state_q      <= S_IDLE;
                     coin_valid_q <= 1'b0;
                  end else begin
                     coin_type_q <= pick(chg_rem);
                  end
               end
            end
         endcase

         // Decrement happens on the edge leaving VEND; a same-cycle restock wins.
         for (int i = 0; i < NUM_ITEMS; i++) begin
            if (restock_en && restock_index == IDX_W'(i))
               inv_q[i] <= restock_count;
            else if (state_q == S_VEND && vidx_q == IDX_W'(i) && inv_q[i] != '0)
               inv_q[i] <= inv_q[i] - 1'b1;
         end
      end
   end

   assign balance      = bal_q;
   assign coin_valid   = coin_valid_q;
   assign coin_type    = coin_type_q;
   assign vend_valid   = vend_valid_q;
   assign vend_index   = vidx_q;
   assign coin_reject  = coin_reject_q;
   assign sold_out     = sold_out_q;
   assign insufficient = insufficient_q;
`ifdef VEND_CREDIT_EN
   assign card_debit       = card_debit_q;
   assign card_debit_valid = card_debit_valid_q;
`endif

endmodule

// File: doc/vending_controller.md
# vending_controller

Parametrised successor to the fixed 8-item vending machine. It covers `NUM_ITEMS` products with a per-item price table, on-chip per-item inventory counters with restock, and an inactivity timeout that auto-refunds. Change is paid out as a greedy quarter/dime/nickel sequence over a valid/ready handshake to the coin dispenser. It sits between the coin acceptor/keypad front end and the dispenser/motor back end.

## Interface
Parameters:
- `NUM_ITEMS`, 8: number of products; index width `IDX_W = $clog2(NUM_ITEMS)`.
- `PRICE_W`, 6: price width per item, in nickel units (5 c).
- `BAL_W`, 7: balance register width, in nickel units.
- `INV_W`, 3: inventory counter width per item.
- `TIMEOUT_CYCLES`, 1000000: idle cycles in COLLECT before auto-cancel.

Ports:
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-low reset.
- `nickel`, `dime`, `quarter`, `dollar` input 1 each: one-cycle coin pulses.
- `select` input 1: one-cycle pulse; selection request.
- `index` input `IDX_W`: item index, sampled when `select`=1.
- `cancel` input 1: one-cycle pulse; refund request.
- `cost` input `NUM_ITEMS*PRICE_W`: flattened price table; item i is at `[i*PRICE_W +: PRICE_W]`.
- `restock_en` input 1; `restock_index` input `IDX_W`; `restock_count` input `INV_W`: overwrite the inventory of one item.
- `coin_ready` input 1: dispenser accepts the presented change coin.
- `coin_valid` output 1; `coin_type` output 2 (01 nickel, 10 dime, 11 quarter): change coin request.
- `vend_valid` output 1; `vend_index` output `IDX_W`: one-cycle vend command.
- `coin_reject` output 1: the inserted coin is returned (pulse).
- `sold_out` output 1; `insufficient` output 1: status pulses.
- `balance` output `BAL_W`: current credit.
- `inventory` output `NUM_ITEMS*INV_W`: current counts.

## Operation
- Coin values in nickel units: nickel 1, dime 2, quarter 5, dollar 20.
- States:
  - IDLE: `balance`=0. A legal coin adds its value and moves to COLLECT.
  - COLLECT: holds the running balance and services `select` and `cancel`.
  - VEND: lasts one cycle.
  - CHANGE: pays out the balance.
- Coin accept happens in IDLE or COLLECT only. A coin is rejected (`coin_reject`=1 the next cycle, balance unchanged) in any of these cases:
  - more than one coin input is high in the same cycle;
  - the new balance would exceed 2^BAL_W−1;
  - the state is VEND or CHANGE.
- `select` in COLLECT:
  - If `index`≥`NUM_ITEMS` or that item's inventory is 0: pulse `sold_out` and stay in COLLECT.
  - Else if `balance` < price: pulse `insufficient` and stay in COLLECT.
  - Else: go to VEND.
  - `select` in IDLE does nothing.
- VEND: `vend_valid`=1 with the latched index; that item's inventory decrements by 1; `balance` decreases by the price. Next state is CHANGE if the remainder is >0, else IDLE.
- `cancel` in COLLECT, or the timeout counter reaching `TIMEOUT_CYCLES`−1, moves to CHANGE. The whole balance is refunded.
- The timeout counter clears on any accepted coin or any `select`, and counts only in COLLECT.
- CHANGE uses a greedy choice:
  - quarter if balance≥5;
  - else dime if balance≥2;
  - else nickel.
- `coin_valid` and `coin_type` stay stable until `coin_ready`. On the handshake the balance is reduced by the coin's value. When the balance reaches 0, go to IDLE.
- Priority within COLLECT in one cycle: `cancel`/timeout, then `select`, then coin. A coin arriving in the same cycle as a successful `select` or a `cancel` is rejected.
- Restock applies in any state. If it targets the item being vended in that same cycle, restock wins.

## Timing
- Reset: state IDLE; `balance`=0; all inventory=0; the timeout counter=0; all outputs 0.
- Reset asserted in mid-CHANGE or mid-VEND abandons the operation on the next edge. Any undispensed balance is lost.
- A coin pulse at edge N shows as the updated `balance` after edge N. `coin_reject` is high for cycle N+1.
- `select` at edge N:
  - the VEND state is entered at N+1;
  - `vend_valid` is high in cycle N+1;
  - the first `coin_valid` appears in N+2.
- `sold_out` and `insufficient` are high in cycle N+1.
- Change throughput is one coin per cycle while `coin_ready`=1.
- All outputs are registered.

## Configuration
- `VEND_CREDIT_EN`
  - Defined:
    - adds inputs `card_present` (1) and `card_funds` (`BAL_W`), and output `card_debit` (`PRICE_W`, plus a valid bit `card_debit_valid`);
    - `select` in IDLE with `card_present`=1, stock available and `card_funds`≥price goes to VEND;
    - it pulses `card_debit_valid` with `card_debit`=price alongside `vend_valid`;
    - no change is paid; the controller returns to IDLE.
  - Undefined: these ports and paths are absent, and `select` in IDLE is ignored.

## Test plan
- Restock item 3 to 2, price 15. Three quarters, then `select` index 3 → `vend_valid` with `vend_index`=3; inventory[3]=1; balance 0; return to IDLE with no `coin_valid`.
- Dollar (20), then `select` item 3 (price 15) → vend, then one quarter presented. Hold `coin_ready`=0 for 5 cycles → `coin_type`=11 stays stable; ready → balance 0, IDLE.
- Dime + nickel (3), then `cancel` → dime, then nickel, then IDLE.
- Inventory[5]=0, balance 20, `select` 5 → `sold_out` pulse; balance stays 20. `select` index 3 with balance 10 → `insufficient`.
- `TIMEOUT_CYCLES`=16, one quarter, no activity → CHANGE after 16 cycles; quarter refunded.
- Nickel and dime in the same cycle → `coin_reject`, balance 0. Reset asserted during CHANGE → all outputs 0 next cycle.
